bennett_phase_monitor: RTL

Receive-side checker and result-capture block for the WIDTH-phase Bennett clock bus (clkp/clkn) driven by the Bennett clock generator into adiabatic datapaths such as the 16-bit adder.
Tracks the charge → full → discharge ramp and flags protocol violations with a sticky error code.
Captures the datapath result while all phases are up, pulses result_valid, and counts completed Bennett cycles.
Sits beside the adder wrapper as the consumer/verifier of the clock bus and the adder output.

---
 rtl/bennett_phase_monitor.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bennett_phase_monitor.sv
// bennett_phase_monitor: Bennett clock-bus ramp checker with sticky error code, result capture and cycle count.
// Define BENNETT_INSTFLAG_CHECK_EN to add the instFlag port and its INSTF consistency check.
module bennett_phase_monitor #(
    parameter int WIDTH     = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_DWELL = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           clkp,
    input  logic [WIDTH-1:0]           clkn,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       err_clear,
`ifdef BENNETT_INSTFLAG_CHECK_EN
    input  logic                       instFlag,
`endif
    output logic [2:0]                 state,
    output logic [$clog2(WIDTH+1)-1:0] level,
    output logic [DATA_W-1:0]          result,
    output logic                       result_valid,
    output logic                       cycle_done,
    output logic [15:0]                cycle_count,
    output logic                       err,
    output logic [2:0]                 err_code
);
    localparam int LW = $clog2(WIDTH + 1);
    localparam int DW = $clog2(MAX_DWELL + 2);
    localparam logic [LW-1:0] L_FULL = LW'(WIDTH);

    typedef enum logic [2:0] {IDLE, CHARGE, FULL, DISCHARGE, ERROR} state_t;

    state_t            state_q;
    logic [LW-1:0]     level_q, level_d;
    logic [DW-1:0]     dwell_q;
    logic [DATA_W-1:0] result_q;
    logic              result_valid_q, cycle_done_q, err_q;
    logic [15:0]       cycle_count_q;
    logic [2:0]        err_code_q, code_d;
    logic              compl_bad, shape_bad, skip_bad, dir_bad, tmo_bad, inst_bad;
    logic              hold, up, dn;

    always_comb begin
        level_d = '0;
        for (int i = 0; i < WIDTH; i++) level_d = level_d + LW'(clkp[i]);
    end

    assign up   = level_d > level_q;
    assign dn   = level_d < level_q;
    // A ramp state that is about to advance is not dwelling (matters only for WIDTH=1)
    assign hold = !up && !dn && ((state_q == CHARGE && level_d != L_FULL) ||
                                 (state_q == DISCHARGE && level_d != '0));

    assign compl_bad = clkn != ~clkp;
    assign shape_bad = ((clkp + WIDTH'(1)) & clkp) != '0;
    assign skip_bad  = (int'(level_d) > int'(level_q) + 1) || (int'(level_q) > int'(level_d) + 1);
    assign dir_bad   = (state_q == CHARGE && dn) || ((state_q == FULL || state_q == DISCHARGE) && up);
    assign tmo_bad   = hold && dwell_q == DW'(MAX_DWELL);
`ifdef BENNETT_INSTFLAG_CHECK_EN
    assign inst_bad  = instFlag != (level_d == L_FULL);
`else
    assign inst_bad  = 1'b0;
`endif

    assign code_d = compl_bad ? 3'd1 : shape_bad ? 3'd2 : skip_bad ? 3'd3 :
                    dir_bad   ? 3'd4 : tmo_bad   ? 3'd5 : inst_bad ? 3'd6 : 3'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            level_q        <= '0;
            dwell_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            cycle_done_q   <= 1'b0;
            cycle_count_q  <= '0;
            err_q          <= 1'b0;
            err_code_q     <= 3'd0;
        end else begin
            result_valid_q <= 1'b0;
            cycle_done_q   <= 1'b0;
            if (state_q == ERROR) begin
                if (err_clear && level_d == '0 && !compl_bad && !inst_bad) begin
                    state_q    <= IDLE;
                    level_q    <= '0;
                    dwell_q    <= '0;
                    err_q      <= 1'b0;
                    err_code_q <= 3'd0;
                end
            end else if (code_d != 3'd0) begin
                state_q    <= ERROR;
                level_q    <= level_d;
                err_q      <= 1'b1;
                err_code_q <= code_d;
            end else begin
                level_q <= level_d;
                dwell_q <= hold ? dwell_q + DW'(1) : '0;
                case (state_q)
                    IDLE:      if (level_d == LW'(1)) state_q <= CHARGE;
                    CHARGE:    if (level_d == L_FULL) begin
                        state_q        <= FULL;
                        result_q       <= data_in;
                        result_valid_q <= 1'b1;
                    end
                    FULL:      if (level_d == L_FULL - LW'(1)) state_q <= DISCHARGE;
                    DISCHARGE: if (level_d == '0) begin
                        state_q       <= IDLE;
                        cycle_done_q  <= 1'b1;
                        cycle_count_q <= cycle_count_q + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state        = state_q;
    assign level        = level_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign cycle_done   = cycle_done_q;
    assign cycle_count  = cycle_count_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
endmodule
